// File: rtl/memoria_datos_ctrl_pkg.sv
// rtl/memoria_datos_ctrl_pkg.sv - shared encodings for the data-memory controller
// Access-size select codes, sign-bit position and dump FSM states.
package memoria_datos_ctrl_pkg;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_BYTE = 2'd1;
  localparam logic [1:0] SEL_HALF = 2'd2;
  localparam logic [1:0] SEL_WORD = 2'd3;
  localparam int         SEL_SIGN_BIT = 2;

  typedef enum logic [1:0] {
    DUMP_IDLE    = 2'd0,
    DUMP_READ    = 2'd1,
    DUMP_PRESENT = 2'd2,
    DUMP_DONE    = 2'd3
  } dump_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == SEL_HALF) && lsb[0]) || ((size == SEL_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/memoria_datos_ctrl_ram.sv
// rtl/memoria_datos_ctrl_ram.sv - single-port RAM with per-column write enables
// Read data is the pre-write word; the controller registers it on the same edge as the write.
module ram_byte_enable #(
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int DEPTH     = 1024
) (
  input  logic                          i_clock,
  input  logic [NB_COL-1:0]             i_we,
  input  logic [$clog2(DEPTH)-1:0]      i_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   i_din,
  output logic [NB_COL*COL_WIDTH-1:0]   o_dout
);

  logic [NB_COL*COL_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    for (int c = 0; c < NB_COL; c++) begin
      if (i_we[c]) begin
        r_mem[i_addr][c*COL_WIDTH +: COL_WIDTH] <= i_din[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  assign o_dout = r_mem[i_addr];

endmodule

// File: rtl/memoria_datos_ctrl.sv
// rtl/memoria_datos_ctrl.sv - data memory controller with byte/half/word stores and debug dump
// CPU accesses are blocked while the dump FSM walks the RAM word by word.
module memoria_datos_ctrl
  import memoria_datos_ctrl_pkg::*;
#(
  parameter int INPUT_OUTPUT_LENGTH             = 32,
  parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 3,
  parameter int CANT_COLUMNAS_MEM_DATOS         = 4,
  parameter int RAM_DEPTH                       = 1024
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic [$clog2(RAM_DEPTH)+1:0]               i_address,
  input  logic [INPUT_OUTPUT_LENGTH-1:0]             i_dato,
  input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_select_op,
  input  logic                                       i_mem_read,
  input  logic                                       i_mem_write,
  input  logic                                       i_dump_start,
  input  logic                                       i_dump_ack,
  output logic [INPUT_OUTPUT_LENGTH-1:0]             o_dato_mem,
  output logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] o_select_op,
  output logic [1:0]                                 o_address_mem_LSB,
  output logic                                       o_misaligned,
  output logic [INPUT_OUTPUT_LENGTH-1:0]             o_dump_dato,
  output logic                                       o_dump_valid,
  output logic                                       o_dump_done
);

  localparam int NCOL    = CANT_COLUMNAS_MEM_DATOS;
  localparam int COL_W   = INPUT_OUTPUT_LENGTH / NCOL;
  localparam int WORD_AW = $clog2(RAM_DEPTH);
  localparam logic [WORD_AW-1:0] LAST_WORD = WORD_AW'(RAM_DEPTH - 1);
  localparam logic [NCOL-1:0]    BYTE_MASK = NCOL'(1);
  localparam logic [NCOL-1:0]    HALF_MASK = NCOL'(3);

  dump_state_t                               r_state, w_next_state;
  logic [WORD_AW-1:0]                        r_counter;
  logic [INPUT_OUTPUT_LENGTH-1:0]            r_dump_dato;
  logic [INPUT_OUTPUT_LENGTH-1:0]            r_dato_mem;
  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] r_select_op;
  logic [1:0]                                r_lsb;
  logic                                      r_misaligned;

  logic                           w_busy;
  logic [1:0]                     w_size;
  logic [1:0]                     w_lsb;
  logic                           w_misaligned;
  logic [WORD_AW-1:0]             w_word_addr;
  logic [WORD_AW-1:0]             w_ram_addr;
  logic [NCOL-1:0]                w_we;
  logic [INPUT_OUTPUT_LENGTH-1:0] w_din;
  logic [INPUT_OUTPUT_LENGTH-1:0] w_rd_data;

  assign w_busy       = (r_state != DUMP_IDLE);
  assign w_size       = i_select_op[1:0];
  assign w_lsb        = i_address[1:0];
  assign w_word_addr  = i_address[WORD_AW+1:2];
  assign w_misaligned = is_misaligned(w_size, w_lsb);
  assign w_ram_addr   = w_busy ? r_counter : w_word_addr;

  // Lane replication: every column sees the data its size would place there.
  always_comb begin
    w_din = '0;
    w_we  = '0;
    case (w_size)
      SEL_BYTE: begin
        for (int c = 0; c < NCOL; c++) w_din[c*COL_W +: COL_W] = i_dato[COL_W-1:0];
        w_we = BYTE_MASK << w_lsb;
      end
      SEL_HALF: begin
        for (int c = 0; c < NCOL; c++) w_din[c*COL_W +: COL_W] = i_dato[(c % 2)*COL_W +: COL_W];
        w_we = HALF_MASK << {w_lsb[1], 1'b0};
      end
      SEL_WORD: begin
        w_din = i_dato;
        w_we  = '1;
      end
      default: ;
    endcase
    if (!i_mem_write || w_busy || w_misaligned || (w_size == SEL_NONE)) w_we = '0;
  end

  ram_byte_enable #(
    .NB_COL   (NCOL),
    .COL_WIDTH(COL_W),
    .DEPTH    (RAM_DEPTH)
  ) u_ram (
    .i_clock(i_clock),
    .i_we   (w_we),
    .i_addr (w_ram_addr),
    .i_din  (w_din),
    .o_dout (w_rd_data)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_dato_mem   <= '0;
      r_select_op  <= '0;
      r_lsb        <= '0;
      r_misaligned <= 1'b0;
    end else if (!w_busy) begin
      r_misaligned <= (i_mem_read || i_mem_write) && w_misaligned;
      if (i_mem_read) begin
        r_dato_mem  <= w_rd_data;
        r_select_op <= i_select_op;
        r_lsb       <= w_lsb;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= DUMP_IDLE;
      r_counter   <= '0;
      r_dump_dato <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == DUMP_IDLE) && i_dump_start) begin
        r_counter <= '0;
      end else if ((r_state == DUMP_PRESENT) && i_dump_ack && (r_counter != LAST_WORD)) begin
        r_counter <= r_counter + 1'b1;
      end
      if (r_state == DUMP_READ) r_dump_dato <= w_rd_data;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DUMP_IDLE:    if (i_dump_start) w_next_state = DUMP_READ;
      DUMP_READ:    w_next_state = DUMP_PRESENT;
      DUMP_PRESENT: if (i_dump_ack) w_next_state = (r_counter == LAST_WORD) ? DUMP_DONE : DUMP_READ;
      DUMP_DONE:    w_next_state = DUMP_IDLE;
      default:      w_next_state = DUMP_IDLE;
    endcase
  end

  assign o_dato_mem        = r_dato_mem;
  assign o_select_op       = r_select_op;
  assign o_address_mem_LSB = r_lsb;
  assign o_misaligned      = r_misaligned;
  assign o_dump_dato       = r_dump_dato;
  assign o_dump_valid      = (r_state == DUMP_PRESENT);
  assign o_dump_done       = (r_state == DUMP_DONE);

endmodule

// File: tb/tb_memoria_datos_ctrl.sv
// tb/tb_memoria_datos_ctrl.sv - self-checking bench for memoria_datos_ctrl
// Instance A (1024 words) covers CPU accesses; instance B (4 words) covers the dump.
module tb_memoria_datos_ctrl;

  logic        clk = 1'b0;
  logic        rst, wr, rd, dstart, dack;
  logic [2:0]  sel;
  logic [11:0] addr;
  logic [31:0] dato;

  logic [31:0] a_dato_mem, a_ddato, b_dato_mem, b_ddato;
  logic [2:0]  a_sel, b_sel;
  logic [1:0]  a_lsb, b_lsb;
  logic        a_mis, a_dvalid, a_ddone, b_mis, b_dvalid, b_ddone;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  memoria_datos_ctrl u_a (
    .i_clock(clk), .i_reset(rst), .i_address(addr), .i_dato(dato), .i_select_op(sel),
    .i_mem_read(rd), .i_mem_write(wr), .i_dump_start(dstart), .i_dump_ack(dack),
    .o_dato_mem(a_dato_mem), .o_select_op(a_sel), .o_address_mem_LSB(a_lsb),
    .o_misaligned(a_mis), .o_dump_dato(a_ddato), .o_dump_valid(a_dvalid), .o_dump_done(a_ddone)
  );

  memoria_datos_ctrl #(.RAM_DEPTH(4)) u_b (
    .i_clock(clk), .i_reset(rst), .i_address(addr[3:0]), .i_dato(dato), .i_select_op(sel),
    .i_mem_read(rd), .i_mem_write(wr), .i_dump_start(dstart), .i_dump_ack(dack),
    .o_dato_mem(b_dato_mem), .o_select_op(b_sel), .o_address_mem_LSB(b_lsb),
    .o_misaligned(b_mis), .o_dump_dato(b_ddato), .o_dump_valid(b_dvalid), .o_dump_done(b_ddone)
  );

  typedef struct {
    logic        wr, rd;
    logic [2:0]  sel;
    logic [11:0] addr;
    logic [31:0] dato;
    logic [31:0] e_dato;
    logic [2:0]  e_sel;
    logic [1:0]  e_lsb;
    logic        e_mis;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  m[64];
  logic [31:0] bw[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [2:0] s,
                       input logic [11:0] a, input logic [31:0] d);
    wr = w; rd = r; sel = s; addr = a; dato = d;
  endtask

  task automatic wait_dump_valid();
    int t = 0;
    while (!b_dvalid && t < 8) begin
      tick();
      t++;
    end
    check("dump_wait_valid", 32'(b_dvalid), 32'd1);
  endtask

  initial begin
    logic [31:0] e_dato;
    logic [2:0]  e_sel;
    logic [1:0]  e_lsb;
    logic        e_mis, mis;
    int          nbytes, base;

    rst = 1'b1; dstart = 1'b0; dack = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 12'h0, 32'h0);
    #12;
    check("reset_dato", a_dato_mem, 32'h0);
    check("reset_sel", 32'(a_sel), 32'h0);
    check("reset_lsb", 32'(a_lsb), 32'h0);
    check("reset_mis", 32'(a_mis), 32'h0);
    check("reset_dvalid", 32'(b_dvalid), 32'h0);
    check("reset_ddone", 32'(b_ddone), 32'h0);
    check("reset_ddato", b_ddato, 32'h0);
    rst = 1'b0;
    tick();

    // wr, rd, sel, addr, dato -> expected dato, sel, lsb, misaligned on the following cycle
    vecs.push_back('{1, 0, 3'd3, 12'h004, 32'h00000000, 32'h00000000, 3'd0, 2'd0, 0});
    vecs.push_back('{1, 0, 3'd1, 12'h006, 32'h000000AB, 32'h00000000, 3'd0, 2'd0, 0});
    vecs.push_back('{0, 1, 3'd5, 12'h006, 32'h0,        32'h00AB0000, 3'd5, 2'd2, 0});
    vecs.push_back('{1, 0, 3'd3, 12'h008, 32'hFFFFFFFF, 32'h00AB0000, 3'd5, 2'd2, 0});
    vecs.push_back('{1, 0, 3'd2, 12'h00A, 32'h00001234, 32'h00AB0000, 3'd5, 2'd2, 0});
    vecs.push_back('{0, 1, 3'd3, 12'h008, 32'h0,        32'h1234FFFF, 3'd3, 2'd0, 0});
    vecs.push_back('{1, 0, 3'd3, 12'h010, 32'h11111111, 32'h1234FFFF, 3'd3, 2'd0, 0});
    vecs.push_back('{1, 0, 3'd3, 12'h011, 32'hDEADBEEF, 32'h1234FFFF, 3'd3, 2'd0, 1});
    vecs.push_back('{0, 1, 3'd3, 12'h010, 32'h0,        32'h11111111, 3'd3, 2'd0, 0});
    vecs.push_back('{1, 0, 3'd2, 12'h00B, 32'h00009999, 32'h11111111, 3'd3, 2'd0, 1});
    vecs.push_back('{0, 1, 3'd3, 12'h008, 32'h0,        32'h1234FFFF, 3'd3, 2'd0, 0});
    vecs.push_back('{1, 1, 3'd1, 12'h010, 32'h00000055, 32'h11111111, 3'd1, 2'd0, 0});
    vecs.push_back('{0, 1, 3'd3, 12'h010, 32'h0,        32'h11111155, 3'd3, 2'd0, 0});
    vecs.push_back('{1, 0, 3'd0, 12'h010, 32'h77777777, 32'h11111155, 3'd3, 2'd0, 0});
    vecs.push_back('{0, 1, 3'd3, 12'h010, 32'h0,        32'h11111155, 3'd3, 2'd0, 0});
    vecs.push_back('{0, 0, 3'd3, 12'h000, 32'h0,        32'h11111155, 3'd3, 2'd0, 0});
    vecs.push_back('{1, 0, 3'd1, 12'h013, 32'h000000C3, 32'h11111155, 3'd3, 2'd0, 0});
    vecs.push_back('{0, 1, 3'd2, 12'h012, 32'h0,        32'hC3111155, 3'd2, 2'd2, 0});
    vecs.push_back('{0, 1, 3'd3, 12'h011, 32'h0,        32'hC3111155, 3'd3, 2'd1, 1});

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].sel, vecs[i].addr, vecs[i].dato);
      tick();
      check($sformatf("vec%0d_dato", i), a_dato_mem, vecs[i].e_dato);
      check($sformatf("vec%0d_sel", i), 32'(a_sel), 32'(vecs[i].e_sel));
      check($sformatf("vec%0d_lsb", i), 32'(a_lsb), 32'(vecs[i].e_lsb));
      check($sformatf("vec%0d_mis", i), 32'(a_mis), 32'(vecs[i].e_mis));
    end

    // Random traffic against a byte-addressed little-endian memory model
    for (int w = 0; w < 16; w++) begin
      drive(1'b1, 1'b0, 3'd3, 12'(w * 4), $urandom);
      for (int b = 0; b < 4; b++) m[w*4 + b] = dato[8*b +: 8];
      tick();
    end
    e_dato = 32'hC3111155; e_sel = 3'd3; e_lsb = 2'd1;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            12'($urandom_range(0, 63)), $urandom);
      nbytes = (sel[1:0] == 2'd0) ? 0 : (1 << (sel[1:0] - 1));
      mis    = (nbytes > 1) && ((int'(addr) % nbytes) != 0);
      base   = int'(addr) - (int'(addr) % 4);
      if (rd) begin
        e_dato = {m[base+3], m[base+2], m[base+1], m[base]};
        e_sel  = sel;
        e_lsb  = 2'(int'(addr) % 4);
      end
      e_mis = (wr || rd) && mis;
      if (wr && !mis)
        for (int b = 0; b < nbytes; b++) m[int'(addr) + b] = dato[8*b +: 8];
      tick();
      check($sformatf("rnd%0d_dato", i), a_dato_mem, e_dato);
      check($sformatf("rnd%0d_sel", i), 32'(a_sel), 32'(e_sel));
      check($sformatf("rnd%0d_lsb", i), 32'(a_lsb), 32'(e_lsb));
      check($sformatf("rnd%0d_mis", i), 32'(a_mis), 32'(e_mis));
    end

    // Dump of the 4-word instance with each ack delayed by 3 cycles
    for (int w = 0; w < 4; w++) begin
      bw[w] = $urandom;
      drive(1'b1, 1'b0, 3'd3, 12'(w * 4), bw[w]);
      tick();
    end
    drive(1'b0, 1'b1, 3'd3, 12'h00C, 32'h0);
    tick();
    check("pre_dump_read", b_dato_mem, bw[3]);
    drive(1'b0, 1'b0, 3'd3, 12'h0, 32'h0);
    dstart = 1'b1;
    tick();
    dstart = 1'b0;
    drive(1'b1, 1'b1, 3'd3, 12'h000, 32'hBADBAD00);
    for (int k = 0; k < 4; k++) begin
      wait_dump_valid();
      check($sformatf("dump%0d_dato", k), b_ddato, bw[k]);
      for (int h = 0; h < 3; h++) begin
        dstart = (h == 0);
        tick();
        check($sformatf("dump%0d_hold_valid", k), 32'(b_dvalid), 32'd1);
        check($sformatf("dump%0d_hold_dato", k), b_ddato, bw[k]);
        check($sformatf("dump%0d_done_low", k), 32'(b_ddone), 32'd0);
      end
      dstart = 1'b0;
      dack = 1'b1;
      tick();
      dack = 1'b0;
      check($sformatf("dump%0d_post_ack_valid", k), 32'(b_dvalid), 32'd0);
      check($sformatf("dump%0d_done", k), 32'(b_ddone), 32'(k == 3));
    end
    tick();
    check("done_one_cycle", 32'(b_ddone), 32'd0);
    check("cpu_hold_dato", b_dato_mem, bw[3]);
    check("cpu_hold_lsb", 32'(b_lsb), 32'd0);
    drive(1'b0, 1'b1, 3'd3, 12'h000, 32'h0);
    tick();
    check("write_blocked_in_dump", b_dato_mem, bw[0]);

    // Reset while presenting word 2, then restart from word 0
    drive(1'b0, 1'b0, 3'd0, 12'h0, 32'h0);
    dstart = 1'b1;
    tick();
    dstart = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_dump_valid();
      dack = 1'b1;
      tick();
      dack = 1'b0;
    end
    wait_dump_valid();
    check("rst_pre_word2", b_ddato, bw[2]);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(b_dvalid), 32'd0);
    check("rst_async_ddato", b_ddato, 32'h0);
    check("rst_async_dato", b_dato_mem, 32'h0);
    #3 rst = 1'b0;
    tick();
    dstart = 1'b1;
    tick();
    dstart = 1'b0;
    wait_dump_valid();
    check("restart_word0", b_ddato, bw[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
